// File: rtl/mdu_iter_if.sv
// Bus between the EX stage / hazard unit and the iterative MDU.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Signed ops run on magnitudes; signs are fixed up on the final edge.
// The last iteration step is folded into the FINISH edge, so busy covers
// WIDTH cycles and hi/lo update WIDTH edges after the launch edge.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  mdu_iter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;   // partial product high half / remainder
  logic [WIDTH-1:0]   sh_q;    // multiplier / dividend-quotient shifter
  logic [WIDTH-1:0]   m_q;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   a_q;     // original dividend for divide-by-zero
  logic               div_q, neg_p_q, neg_r_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, busy_c;

  logic               launch;
  logic               sgn_l;
  logic [WIDTH-1:0]   ma, mb;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   acc_n, sh_n;
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0]   q_c, r_c, hi_r, lo_r;

  assign launch = !bus.cancel && bus.start && !bus.op[2];

  // Operand magnitudes for launch (signed ops only)
  always_comb begin
    sgn_l = ~bus.op[0];
    ma    = (sgn_l && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    mb    = (sgn_l && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    div_tmp = {acc_q, sh_q[WIDTH-1]};
    div_ge  = div_tmp >= {1'b0, m_q};
    // tmp-d < d whenever it is taken, so the low WIDTH bits suffice
    div_sub = div_tmp[WIDTH-1:0] - m_q;
    if (div_q) begin
      acc_n = div_ge ? div_sub : div_tmp[WIDTH-1:0];
      sh_n  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      sh_n  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override of the final step
  always_comb begin
    prod   = {acc_n, sh_n};
    prod_c = neg_p_q ? (~prod + 1'b1) : prod;
    q_c    = neg_p_q ? (~sh_n + 1'b1) : sh_n;
    r_c    = neg_r_q ? (~acc_n + 1'b1) : acc_n;
    if (!div_q) begin
      hi_r = prod_c[2*WIDTH-1:WIDTH];
      lo_r = prod_c[WIDTH-1:0];
    end else if (dz_q) begin
      hi_r = a_q;
      lo_r = {WIDTH{1'b1}};
    end else begin
      hi_r = r_c;
      lo_r = q_c;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; cancel wins everywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      // counter becomes 1 on this edge -> final step happens in FINISH
      RUN:     if (bus.cancel) state_d = IDLE;
               else if (cnt_q == CNT_W'(2)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_c = (state_q != IDLE);
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            cnt_q   <= CNT_W'(WIDTH);
            acc_q   <= '0;
            div_q   <= bus.op[1];
            a_q     <= bus.a;
            dz_q    <= (bus.b == '0);
            neg_p_q <= sgn_l && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r_q <= sgn_l && bus.op[1] && bus.a[WIDTH-1];
            sh_q    <= bus.op[1] ? ma : mb;
            m_q     <= bus.op[1] ? mb : ma;
          end else if (!bus.cancel && bus.start && bus.op[2:1] == 2'b10) begin
            if (bus.op[0]) lo_q <= bus.a;
            else           hi_q <= bus.a;
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            acc_q <= acc_n;
            sh_q  <= sh_n;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FINISH: begin
          if (!bus.cancel) begin
            hi_q   <= hi_r;
            lo_q   <= lo_r;
            done_q <= 1'b1;
          end
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline.
- EX stage launches MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- hi/lo outputs feed the 8:1 writeback/result select mux, which already has HI and LO inputs for MFHI/MFLO.
- busy goes to the hazard unit, which stalls MFHI/MFLO and new MDU ops while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and >=4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request, sampled at rising edge.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- b  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  pipeline flush; aborts an in-flight operation.
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  one-cycle pulse when hi/lo take a new iterative result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - Asserting rst_n low clears busy, done, hi, lo and all internal state to 0 immediately, including mid-operation.
  - Release is synchronous to clk.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU: latch operands and op, load counter=WIDTH, go to RUN. busy=1 from the next cycle.
  - start=1 with MTHI: hi<=a at that edge. With MTLO: lo<=a at that edge. Stay IDLE; no busy, no done.
  - op 11x is ignored.
- RUN:
  - One radix-2 step per cycle: shift-add multiply, or restoring divide. Counter decrements each cycle.
  - When the counter reaches 1, go to FINISH on that edge.
  - busy is high for exactly WIDTH cycles in total.
- FINISH:
  - This edge writes hi/lo with the sign-corrected result, sets busy=0 and done=1, and returns to IDLE.
  - done is high for exactly one cycle.
  - Total latency is WIDTH+1 edges from the start edge to hi/lo update.
- Start while busy:
  - start is ignored while busy=1, including MTHI/MTLO.
  - Nothing is queued. The hazard unit is responsible for not issuing.
- hi/lo hold their previous values throughout RUN. No partial results are exposed.
- Signed ops (MULT, DIV):
  - Take magnitudes of a and b, run the unsigned engine, then correct signs.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
- Divide result: lo = quotient, hi = remainder.
- Divide by zero: still takes the full latency. lo = all ones, hi = a (the original, uncorrected dividend), for both DIV and DIVU.
- Signed overflow, most-negative divided by -1: lo = 100...0 and hi = 0, by natural wrap. No exception is raised.
- cancel:
  - In RUN or FINISH: return to IDLE on that edge, busy=0 next cycle, no done, hi/lo unchanged.
  - In IDLE: cancel has priority over start. The op is dropped, MTHI/MTLO included.
- Simultaneous done and start: not possible, because start is ignored until busy=0. A start in the cycle done is high is accepted normally.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high 32 cycles; at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses 1 cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands -> hi=0, lo=1.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Start DIVU 100/7, then at RUN cycle 5 pulse start with MTHI a=0x55 -> ignored; final hi=2, lo=14.
- MTLO a=0x1234 in IDLE -> lo=0x1234 next edge, busy never asserted, done never asserted.
- Launch MULT, assert cancel at RUN cycle 10 -> busy low next cycle, no done, hi/lo keep prior values. Repeat with rst_n low at RUN cycle 10 -> busy/done/hi/lo=0 asynchronously.
